// File: rtl/wishbone_rr_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic slave port between NM masters.
// A grant is held for the owner's whole CYC; a watchdog turns a missing ACK into ERR.
module wishbone_rr_arbiter #(
  parameter int NM      = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AW-1:0]     m_addr_i,
  input  logic [NM*DW-1:0]     m_data_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  output logic [NM*DW-1:0]     m_data_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [NM-1:0]        gnt_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_addr_o,
  output logic [DW-1:0]        s_data_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic [DW-1:0]        s_data_i,
  input  logic                 s_ack_i
);

  localparam int IW = $clog2(NM);
  localparam int SW = DW / 8;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [NM-1:0]   gnt_q, gnt_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [WW-1:0]   wdog_q, wdog_d;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            busy, cyc_g, stb_g, err_now;

  assign busy  = (state_q == BUSY);
  assign cyc_g = |(m_cyc_i & gnt_q);
  assign stb_g = |(m_stb_i & gnt_q);

  // ACK in the timeout cycle wins, so the watchdog only fires without one.
  assign err_now = busy && stb_g && !s_ack_i && (wdog_q == WW'(TIMEOUT - 1));

  // Rotating priority scan: first requester after the previous owner, with wrap.
  always_comb begin
    logic [IW:0] cand;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NM; i++) begin
      cand = {1'b0, last_q} + (IW + 1)'(i);
      if (cand >= (IW + 1)'(NM)) cand = cand - (IW + 1)'(NM);
      if (!pick_vld && m_cyc_i[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = BUSY;
          gidx_d  = pick_idx;
          for (int k = 0; k < NM; k++) gnt_d[k] = (pick_idx == IW'(k));
        end
      end
      BUSY: begin
        if (!cyc_g) begin
          state_d = IDLE;
          gnt_d   = '0;
          last_d  = gidx_q;
        end
      end
    endcase
  end

  // The masked STB on an ERR cycle also clears the counter.
  assign wdog_d = (busy && cyc_g && s_stb_o && !s_ack_i) ? wdog_q + WW'(1) : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NM - 1);
      wdog_q  <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  // The grant vector is all-zero in IDLE, so the one-hot mux idles at 0.
  always_comb begin
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    s_sel_o  = '0;
    m_data_o = '0;
    for (int k = 0; k < NM; k++) begin
      if (gnt_q[k]) begin
        s_we_o   = m_we_i[k];
        s_addr_o = m_addr_i[k*AW +: AW];
        s_data_o = m_data_i[k*DW +: DW];
        s_sel_o  = m_sel_i[k*SW +: SW];
        m_data_o[k*DW +: DW] = s_data_i;
      end
    end
  end

  assign s_cyc_o = busy;
  assign s_stb_o = busy && stb_g && !err_now;
  assign gnt_o   = gnt_q;
  assign m_ack_o = {NM{s_ack_i}} & gnt_q & m_stb_i;
  assign m_err_o = {NM{err_now}} & gnt_q;

endmodule

// File: tb/tb_wishbone_rr_arbiter.sv
// Scoreboard bench for wishbone_rr_arbiter: directed master traffic against a
// registered-ACK memory model; a negedge monitor pops expected responses.
module tb_wishbone_rr_arbiter;

  localparam int NM      = 3;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [NM-1:0]    m_cyc  = '0;
  logic [NM-1:0]    m_stb  = '0;
  logic [NM-1:0]    m_we   = '0;
  logic [NM*AW-1:0] m_addr = '0;
  logic [NM*DW-1:0] m_wdat = '0;
  logic [NM*SW-1:0] m_sel  = '0;

  logic [NM*DW-1:0] m_data_o;
  logic [NM-1:0]    m_ack_o, m_err_o, gnt_o;
  logic             s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]    s_addr_o;
  logic [DW-1:0]    s_data_o;
  logic [SW-1:0]    s_sel_o;
  logic [DW-1:0]    s_data_i;
  logic             s_ack_i;

  wishbone_rr_arbiter #(.NM(NM), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_we_i   (m_we),
    .m_addr_i (m_addr),
    .m_data_i (m_wdat),
    .m_sel_i  (m_sel),
    .m_data_o (m_data_o),
    .m_ack_o  (m_ack_o),
    .m_err_o  (m_err_o),
    .gnt_o    (gnt_o),
    .s_cyc_o  (s_cyc_o),
    .s_stb_o  (s_stb_o),
    .s_we_o   (s_we_o),
    .s_addr_o (s_addr_o),
    .s_data_o (s_data_o),
    .s_sel_o  (s_sel_o),
    .s_data_i (s_data_i),
    .s_ack_i  (s_ack_i)
  );

  // Memory slave model: ACK after ack_delay STB cycles (0 = never).
  int   ack_delay = 1;
  int   s_cnt     = 0;
  logic ack_q     = 1'b0;

  function automatic logic [31:0] rd_value(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : {16'hCAFE, a[15:0]};
  endfunction

  always @(posedge clk_i) begin
    if (ack_q) begin
      ack_q <= 1'b0;
      s_cnt <= 0;
    end else if (s_stb_o) begin
      if (s_cnt + 1 == ack_delay) ack_q <= 1'b1;
      s_cnt <= s_cnt + 1;
    end else begin
      s_cnt <= 0;
    end
  end

  assign s_ack_i  = ack_q;
  assign s_data_i = ack_q ? rd_value(s_addr_o) : '0;

  typedef struct {
    bit          is_err;
    int          mst;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int acks_per[NM];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_resp(input int k, input bit is_err, input bit chk, input logic [31:0] d);
    exp_t e;
    e.is_err = is_err; e.mst = k; e.chk_data = chk; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_t w;
    w.addr = a; w.data = d; w.sel = s;
    wr_q.push_back(w);
  endtask

  // Monitor: pops the scoreboard on every ACK/ERR and checks bus invariants.
  logic [NM-1:0] prev_gnt = '0;
  int            stb_run  = 0;

  always @(negedge clk_i) begin
    exp_t             e;
    wr_t              w;
    logic [NM*DW-1:0] msk;
    if (rst_i) begin
      check("gnt_onehot0", $onehot0(gnt_o), 1);
      if (gnt_o != prev_gnt) begin
        check("dead_cycle", (prev_gnt == '0) || (gnt_o == '0), 1);
        prev_gnt = gnt_o;
      end
      for (int k = 0; k < NM; k++) begin
        if (m_ack_o[k] || m_err_o[k]) begin
          check("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sb_master", k, e.mst);
            check("sb_err_flag", m_err_o[k], e.is_err);
            if (e.chk_data) check("sb_rdata", m_data_o[k*DW +: DW], e.data);
          end
          msk = '0;
          msk[k*DW +: DW] = '1;
          check("other_data_zero", m_data_o & ~msk, 0);
          if (m_err_o[k]) begin
            check("err_stb_masked", s_stb_o, 0);
            check("err_stb_cycles", stb_run, TIMEOUT - 1);
          end
          if (m_ack_o[k]) acks_per[k]++;
        end
      end
      if (s_stb_o && s_ack_i && s_we_o) begin
        check("wr_nonempty", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          w = wr_q.pop_front();
          check("wr_addr", s_addr_o, w.addr);
          check("wr_data", s_data_o, w.data);
          check("wr_sel", s_sel_o, w.sel);
        end
      end
      if (s_stb_o && !s_ack_i) stb_run++;
      else stb_run = 0;
    end else begin
      prev_gnt = '0;
      stb_run  = 0;
    end
  end

  // One CYC of n beats from master k; call at a point away from the rising edge.
  task automatic burst(input int k, input int n, input bit we, input logic [31:0] base,
                       input logic [31:0] wd, input logic [3:0] sel);
    int t;
    m_cyc[k] = 1'b1;
    for (int b = 0; b < n; b++) begin
      m_stb[k] = 1'b1;
      m_we[k]  = we;
      m_addr[k*AW +: AW] = base + 32'(4 * b);
      m_wdat[k*DW +: DW] = wd + 32'(b);
      m_sel[k*SW +: SW]  = sel;
      t = 0;
      do begin
        @(negedge clk_i);
        t++;
      end while (!(m_ack_o[k] || m_err_o[k]) && t < 200);
      check("beat_done", t < 200, 1);
      @(posedge clk_i); #1;
      m_stb[k] = 1'b0;
    end
    m_cyc[k] = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic rr_master(input int k);
    for (int j = 0; j < 4; j++)
      burst(k, 1, 1'b0, 32'h400 + 32'(k * 256) + 32'(j * 16), 32'h0, 4'hF);
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int t;
    for (int k = 0; k < NM; k++) acks_per[k] = 0;

    // Reset state: requests and addresses present, outputs must stay 0.
    m_cyc  = '1;
    m_stb  = '1;
    m_addr = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    m_wdat = {32'h6666_6666, 32'h5555_5555, 32'h4444_4444};
    m_sel  = '1;
    repeat (2) @(posedge clk_i);
    #2;
    check("rst_gnt", gnt_o, 0);
    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_s_stb", s_stb_o, 0);
    check("rst_s_addr", s_addr_o, 0);
    check("rst_s_data", s_data_o, 0);
    check("rst_s_sel", s_sel_o, 0);
    check("rst_m_ack", m_ack_o, 0);
    check("rst_m_err", m_err_o, 0);
    m_cyc = '0;
    m_stb = '0;
    m_addr = '0;
    m_wdat = '0;
    m_sel = '0;
    @(posedge clk_i); #1 rst_i = 1'b1;

    // 1: single read by m0, exact latency.
    @(posedge clk_i); #1;
    expect_resp(0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_addr[0 +: AW] = 32'h100;
    m_sel[0 +: SW] = 4'hF;
    @(negedge clk_i);
    check("t1_c0_stb", s_stb_o, 0);
    @(negedge clk_i);
    check("t1_c1_stb", s_stb_o, 1);
    check("t1_c1_addr", s_addr_o, 32'h100);
    check("t1_c1_gnt", gnt_o, 3'b001);
    @(negedge clk_i);
    check("t1_c2_ack", m_ack_o, 3'b001);
    check("t1_c2_data", m_data_o, {64'h0, 32'hDEAD_BEEF});
    @(posedge clk_i); #1;
    m_stb[0] = 1'b0;
    m_cyc[0] = 1'b0;
    @(posedge clk_i); #1;

    // 2: simultaneous requests right after reset -> 0,1,2.
    do_reset();
    expect_resp(0, 1'b0, 1'b1, 32'hCAFE_0200);
    expect_resp(1, 1'b0, 1'b1, 32'hCAFE_0210);
    expect_resp(2, 1'b0, 1'b1, 32'hCAFE_0220);
    fork
      burst(0, 1, 1'b0, 32'h200, 32'h0, 4'hF);
      burst(1, 1, 1'b0, 32'h210, 32'h0, 4'hF);
      burst(2, 1, 1'b0, 32'h220, 32'h0, 4'hF);
    join

    // 3: continuous requests, 12 transfers, strict rotation.
    for (int k = 0; k < NM; k++) acks_per[k] = 0;
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < NM; k++)
        expect_resp(k, 1'b0, 1'b1, 32'hCAFE_0400 + 32'(k * 256) + 32'(j * 16));
    fork
      rr_master(0);
      rr_master(1);
      rr_master(2);
    join
    check("t3_acks_m0", acks_per[0], 4);
    check("t3_acks_m1", acks_per[1], 4);
    check("t3_acks_m2", acks_per[2], 4);

    // 4: m1 holds CYC for three writes while m0 waits.
    expect_wr(32'h10, 32'h1111_0000, 4'b0011);
    expect_wr(32'h14, 32'h1111_0001, 4'b0011);
    expect_wr(32'h18, 32'h1111_0002, 4'b0011);
    expect_resp(1, 1'b0, 1'b0, 32'h0);
    expect_resp(1, 1'b0, 1'b0, 32'h0);
    expect_resp(1, 1'b0, 1'b0, 32'h0);
    expect_resp(0, 1'b0, 1'b1, 32'hCAFE_0300);
    fork
      burst(1, 3, 1'b1, 32'h10, 32'h1111_0000, 4'b0011);
      begin
        t = 0;
        do begin
          @(negedge clk_i);
          t++;
        end while (!gnt_o[1] && t < 50);
        check("t4_m1_granted", gnt_o[1], 1);
        burst(0, 1, 1'b0, 32'h300, 32'h0, 4'hF);
      end
    join

    // 5: no ACK -> ERR at the 16th STB cycle; ACK on that cycle -> no ERR.
    ack_delay = 0;
    expect_resp(2, 1'b1, 1'b0, 32'h0);
    burst(2, 1, 1'b0, 32'h500, 32'h0, 4'hF);
    ack_delay = TIMEOUT - 1;
    expect_resp(2, 1'b0, 1'b1, 32'hCAFE_0504);
    burst(2, 1, 1'b0, 32'h504, 32'h0, 4'hF);
    ack_delay = 1;

    // 6: reset in the cycle the ACK is due.
    m_cyc[0] = 1'b1;
    m_stb[0] = 1'b1;
    m_we[0]  = 1'b0;
    m_addr[0 +: AW] = 32'h600;
    t = 0;
    do begin
      @(negedge clk_i);
      t++;
    end while (!s_stb_o && t < 50);
    check("t6_stb_seen", s_stb_o, 1);
    @(posedge clk_i); #1;
    check("t6_ack_due", m_ack_o, 3'b001);
    rst_i = 1'b0;
    #1;
    check("t6_m_ack", m_ack_o, 0);
    check("t6_m_data", m_data_o, 0);
    check("t6_gnt", gnt_o, 0);
    check("t6_s_cyc", s_cyc_o, 0);
    check("t6_s_stb", s_stb_o, 0);
    check("t6_s_addr", s_addr_o, 0);
    m_cyc = '0;
    m_stb = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    expect_resp(0, 1'b0, 1'b1, 32'hCAFE_0610);
    expect_resp(2, 1'b0, 1'b1, 32'hCAFE_0620);
    fork
      burst(2, 1, 1'b0, 32'h620, 32'h0, 4'hF);
      burst(0, 1, 1'b0, 32'h610, 32'h0, 4'hF);
    join

    repeat (3) @(posedge clk_i);
    check("sb_drained", exp_q.size(), 0);
    check("wr_drained", wr_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
